// File: rtl/sysid_checker.sv
// sysid_checker: reads the two words of an Avalon-MM sysid slave and compares
// them against the expected system ID and build timestamp.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   start               one-cycle request to run a check sequence
//   busy                high while a sequence is in progress (low only in IDLE)
//   done                one-cycle pulse when a sequence finishes
//   id_ok, ts_ok        word 0 / word 1 matched the expected value
//   timeout_err         a command or response phase ran out of wait budget
//   id_value, ts_value  words captured from the slave
//   avm_*               Avalon-MM read master (address selects sysid word)
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1490042261,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // Last count value of a phase; a phase that makes no progress on this
  // count has used all TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD0 = 3'd1,
    RSP0 = 3'd2,
    CMD1 = 3'd3,
    RSP1 = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_d;
  logic                start_q;
  logic                start_q_d;
  logic                cnt_last;

  logic                id_ok_d;
  logic                ts_ok_d;
  logic                timeout_err_d;
  logic [DATA_W-1:0]   id_value_d;
  logic [DATA_W-1:0]   ts_value_d;
  logic                busy_d;
  logic                done_d;
  logic                avm_read_d;
  logic                avm_address_d;

  assign cnt_last = (cnt == CNT_LAST);

  // Next-state, wait counter and result update.
  // The request is registered before the FSM acts on it; it is only taken
  // in IDLE and a request already pending blocks a second one.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    start_q_d     = start & (state == IDLE) & ~start_q;
    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    timeout_err_d = timeout_err;
    id_value_d    = id_value;
    ts_value_d    = ts_value;

    unique case (state)
      IDLE: begin
        if (start_q) begin
          state_d       = CMD0;
          cnt_d         = '0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
          id_value_d    = '0;
          ts_value_d    = '0;
        end
      end

      CMD0: begin
        if (!avm_waitrequest) begin
          state_d = RSP0;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d       = FIN;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      // Data arriving on the last allowed cycle is still captured.
      RSP0: begin
        if (avm_readdatavalid) begin
          state_d    = CMD1;
          cnt_d      = '0;
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
        end else if (cnt_last) begin
          state_d       = FIN;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      CMD1: begin
        if (!avm_waitrequest) begin
          state_d = RSP1;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d       = FIN;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      RSP1: begin
        if (avm_readdatavalid) begin
          state_d    = FIN;
          cnt_d      = '0;
          ts_value_d = avm_readdata;
          ts_ok_d    = (avm_readdata == EXPECTED_TS);
        end else if (cnt_last) begin
          state_d       = FIN;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status and bus outputs are registered from the next state so they line
  // up with the state they describe.
  always_comb begin
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == FIN);
    avm_read_d    = (state_d == CMD0) || (state_d == CMD1);
    avm_address_d = (state_d == CMD1) || (state_d == RSP1);
  end

  // State and wait-counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      start_q <= start_q_d;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      avm_read    <= avm_read_d;
      avm_address <= avm_address_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout_err <= timeout_err_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a behavioural Avalon sysid slave and
// a queue of expected sequence results popped on each done pulse.
module tb_sysid_checker;

  localparam logic [31:0] GOOD_TS = 32'd1490042261;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  sysid_checker #(
    .EXPECTED_ID (32'd0),
    .EXPECTED_TS (GOOD_TS),
    .TIMEOUT     (4)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .ts_value          (ts_value),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave configuration, written by the stimulus between sequences.
  logic [31:0] word0, word1;
  int          wait0, wait1;
  int          dly0, dly1;
  bit          drop0, drop1;
  logic        stray;

  int          wr_cnt;
  bit          pend;
  int          dly;
  logic [31:0] rdata_r;
  logic        rvalid_r;

  assign avm_waitrequest   = avm_read && (wr_cnt < (avm_address ? wait1 : wait0));
  assign avm_readdatavalid = rvalid_r | stray;
  assign avm_readdata      = stray ? 32'hDEAD_BEEF : rdata_r;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt   <= 0;
      pend     <= 1'b0;
      dly      <= 0;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= 1'b0;
      wr_cnt   <= (avm_read && avm_waitrequest) ? wr_cnt + 1 : 0;
      if (avm_read && !avm_waitrequest) begin
        rdata_r <= avm_address ? word1 : word0;
        if (!(avm_address ? drop1 : drop0)) begin
          if ((avm_address ? dly1 : dly0) == 0) rvalid_r <= 1'b1;
          else begin
            pend <= 1'b1;
            dly  <= (avm_address ? dly1 : dly0) - 1;
          end
        end
      end else if (pend) begin
        if (dly == 0) begin
          rvalid_r <= 1'b1;
          pend     <= 1'b0;
        end else dly <= dly - 1;
      end
    end
  end

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        te;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          lat;
    int          rd0;
    int          rd1;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   stray_at = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic slave_cfg(input logic [31:0] w0, input logic [31:0] w1,
                           input int wt0, input int wt1, input int d0, input int d1,
                           input bit dr0, input bit dr1);
    word0 = w0; word1 = w1; wait0 = wt0; wait1 = wt1;
    dly0 = d0; dly1 = d1; drop0 = dr0; drop1 = dr1;
  endtask

  task automatic expect_res(input logic iok, input logic tok, input logic te,
                            input logic [31:0] idv, input logic [31:0] tsv,
                            input int lat, input int rd0, input int rd1);
    e.id_ok = iok; e.ts_ok = tok; e.te = te; e.idv = idv; e.tsv = tsv;
    e.lat = lat; e.rd0 = rd0; e.rd1 = rd1;
  endtask

  // Launch one sequence, wait for done, compare against the queued result,
  // then watch for any further done or busy activity.
  task automatic run_seq(input string tag, input bit extra);
    int   lat, rd0, rd1, post;
    bit   got;
    exp_t x;
    @(negedge clock);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clock);
    lat = 0; rd0 = 0; rd1 = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      start = extra && (lat == 3);
      stray = (lat == stray_at);
      if (avm_read) begin
        if (avm_address) rd1++;
        else rd0++;
      end
      if (done) got = 1'b1;
    end
    stray = 1'b0;
    x = sb.pop_front();
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_latency"}, 64'(lat), 64'(x.lat));
      chk({tag, "_id_ok"}, 64'(id_ok), 64'(x.id_ok));
      chk({tag, "_ts_ok"}, 64'(ts_ok), 64'(x.ts_ok));
      chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(x.te));
      chk({tag, "_id_value"}, 64'(id_value), 64'(x.idv));
      chk({tag, "_ts_value"}, 64'(ts_value), 64'(x.tsv));
      chk({tag, "_rd0_cycles"}, 64'(rd0), 64'(x.rd0));
      chk({tag, "_rd1_cycles"}, 64'(rd1), 64'(x.rd1));
      if (extra) start = 1'b1;
    end
    post = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done || busy || avm_read) post++;
    end
    chk({tag, "_quiet_after"}, 64'(post), 64'd0);
  endtask

  initial begin
    int wcnt;
    reset_n = 1'b0;
    start   = 1'b0;
    stray   = 1'b0;
    slave_cfg(32'd0, GOOD_TS, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("reset_outputs",
        64'({busy, done, id_ok, ts_ok, timeout_err, avm_read, avm_address}), 64'd0);
    chk("reset_values", 64'({id_value, ts_value}), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Matching slave, zero wait; stray valid while the request is pending.
    stray_at = 1;
    expect_res(1'b1, 1'b1, 1'b0, 32'd0, GOOD_TS, 6, 1, 1);
    run_seq("match", 1'b0);

    // Timestamp off by one.
    stray_at = -1;
    slave_cfg(32'd0, 32'd1490042260, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_res(1'b1, 1'b0, 1'b0, 32'd0, 32'd1490042260, 6, 1, 1);
    run_seq("ts_bad", 1'b0);

    // Three stall cycles in CMD0, accepted on the last allowed count;
    // stray valid during the stall must be ignored.
    stray_at = 3;
    slave_cfg(32'd0, GOOD_TS, 3, 0, 0, 0, 1'b0, 1'b0);
    expect_res(1'b1, 1'b1, 1'b0, 32'd0, GOOD_TS, 9, 4, 1);
    run_seq("wait3", 1'b0);

    // ID mismatch.
    stray_at = -1;
    slave_cfg(32'h0000_0005, GOOD_TS, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_res(1'b0, 1'b1, 1'b0, 32'h0000_0005, GOOD_TS, 6, 1, 1);
    run_seq("id_bad", 1'b0);

    // No response to word 0: timeout after four RSP0 cycles, word 1 unread.
    slave_cfg(32'd0, GOOD_TS, 0, 0, 0, 0, 1'b1, 1'b0);
    expect_res(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 7, 1, 0);
    run_seq("rsp0_to", 1'b0);

    // Word 0 data on the same cycle the count expires: capture wins.
    slave_cfg(32'd0, GOOD_TS, 0, 0, 3, 0, 1'b0, 1'b0);
    expect_res(1'b1, 1'b1, 1'b0, 32'd0, GOOD_TS, 9, 1, 1);
    run_seq("rsp0_edge", 1'b0);

    // Word 1 data one cycle too late: timeout in RSP1, late valid in FIN ignored.
    slave_cfg(32'd0, GOOD_TS, 0, 0, 0, 4, 1'b0, 1'b0);
    expect_res(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 9, 1, 1);
    run_seq("rsp1_to", 1'b0);

    // Command never accepted: read drops after four CMD0 cycles.
    slave_cfg(32'd0, GOOD_TS, 10, 0, 0, 0, 1'b0, 1'b0);
    expect_res(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 6, 4, 0);
    run_seq("cmd0_to", 1'b0);

    // Extra start requests while busy and in FIN are ignored.
    slave_cfg(32'd0, GOOD_TS, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_res(1'b1, 1'b1, 1'b0, 32'd0, GOOD_TS, 6, 1, 1);
    run_seq("start_busy", 1'b1);

    // Reset during RSP1 aborts without a done pulse.
    slave_cfg(32'h0000_0007, GOOD_TS, 0, 0, 0, 3, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wcnt = 0;
    while (!(avm_address && !avm_read) && wcnt < 40) begin
      @(negedge clock);
      wcnt++;
    end
    chk("rst_reach_rsp1", 64'(wcnt < 40), 64'd1);
    chk("rst_pre_id_value", 64'(id_value), 64'h7);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        64'({busy, done, id_ok, ts_ok, timeout_err, avm_read, avm_address}), 64'd0);
    chk("rst_mid_values", 64'({id_value, ts_value}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done || busy) wcnt++;
    end
    chk("rst_no_done", 64'(wcnt), 64'd0);

    // Fresh sequence after the abort.
    slave_cfg(32'd0, GOOD_TS, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_res(1'b1, 1'b1, 1'b0, 32'd0, GOOD_TS, 6, 1, 1);
    run_seq("after_rst", 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, system ID value expected at sysid word 0.
REQ-002 Parameter EXPECTED_TS, default 1490042261, build timestamp expected at sysid word 1.
REQ-003 Parameter TIMEOUT, default 255, max wait cycles per read phase; range 1..65535.
REQ-004 Port list (name, direction, width, meaning) SHALL be:
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle check request
- busy  out  1  check sequence in progress
- done  out  1  one-cycle completion pulse
- id_ok  out  1  word 0 matched EXPECTED_ID
- ts_ok  out  1  word 1 matched EXPECTED_TS
- timeout_err  out  1  a read phase exceeded TIMEOUT
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1
- avm_address  out  1  sysid word select
- avm_read  out  1  read command
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- avm_readdatavalid  in  1  read data qualifier

Function
REQ-005 FSM states SHALL be IDLE, CMD0, RSP0, CMD1, RSP1, FIN.
REQ-006 IDLE: start=1 -> CMD0; busy=0 only in IDLE.
REQ-007 CMD0: avm_read=1, avm_address=0, held stable while avm_waitrequest=1; command accepted in cycle with avm_waitrequest=0 -> RSP0.
REQ-008 RSP0: on avm_readdatavalid=1, capture avm_readdata into id_value, set id_ok=(avm_readdata==EXPECTED_ID), -> CMD1.
REQ-009 CMD1/RSP1 SHALL mirror CMD0/RSP0 with avm_address=1, capture into ts_value, ts_ok compare against EXPECTED_TS; RSP1 exit -> FIN.
REQ-010 FIN: done=1 for exactly one cycle, -> IDLE.
REQ-011 avm_read SHALL be 1 only in CMD0/CMD1; avm_address SHALL be 0 outside CMD1/RSP1.
REQ-012 Wait counter (16 bit) SHALL clear on entry to each CMD/RSP state and increment each cycle in that state without progress.
REQ-013 Counter reaching TIMEOUT in any CMD/RSP state SHALL set timeout_err=1, deassert avm_read, -> FIN; uncaptured word leaves its value 0 and ok flag 0.
REQ-014 avm_readdatavalid in same cycle counter reaches TIMEOUT: data capture wins, no timeout_err.
REQ-015 avm_readdatavalid outside RSP0/RSP1 SHALL be ignored.
REQ-016 start while busy=1 or in FIN SHALL be ignored.
REQ-017 On leaving IDLE for CMD0, id_ok, ts_ok, timeout_err, id_value, ts_value SHALL clear to 0; otherwise they hold last result until next start.
REQ-018 Zero-wait slave (waitrequest=0, readdatavalid next cycle): start to done latency SHALL be 6 cycles (start sampled cycle 0, done high cycle 6).

Reset
REQ-019 reset_n=0 SHALL asynchronously force state IDLE, counter 0, and all outputs 0.
REQ-020 Reset asserted mid-sequence SHALL abort with no done pulse; after release block waits in IDLE for new start.

Verification
REQ-021 Matching slave, word0=0, word1=1490042261, zero wait -> done at cycle 6, id_ok=1, ts_ok=1, timeout_err=0, ts_value=1490042261.
REQ-022 Word1 returns 1490042260 -> ts_ok=0, id_ok=1, ts_value=1490042260, timeout_err=0.
REQ-023 avm_waitrequest high 3 cycles in CMD0 -> avm_read and avm_address=0 held 4 cycles, result correct, latency 9.
REQ-024 TIMEOUT=4, readdatavalid never asserted in RSP0 -> timeout_err=1, id_ok=0, id_value=0, done after 4 RSP0 cycles, word 1 never read.
REQ-025 reset_n low during RSP1, then start -> no done until new sequence; new sequence completes with fresh results.
REQ-026 start pulses during busy and in FIN -> single done pulse, no second sequence.
